// File: rtl/latency_timer_multi.sv
// Multi-channel latency timer: one start event, NUM_CH independent stop events,
// latencies counted in ticks of TICK_DIV clocks with per-channel last/max capture.
module latency_timer_multi #(
    parameter int TICK_DIV = 125,
    parameter int CNT_W    = 32,
    parameter int NUM_CH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       stop,
    output logic                    busy,
    output logic [CNT_W-1:0]        elapsed,
    output logic [NUM_CH-1:0]       ch_done,
    output logic                    all_done,
    output logic [NUM_CH*CNT_W-1:0] lat_last,
    output logic [NUM_CH*CNT_W-1:0] lat_max,
    output logic                    overflow
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

    state_t            state;
    logic [PW-1:0]     prescaler;
    logic [CNT_W-1:0]  cap_v;
    logic [NUM_CH-1:0] cap_en;
    logic [NUM_CH-1:0] done_next;

    // Capture rounds up to whole ticks and uses the pre-increment count.
    assign cap_v     = (elapsed == CNT_MAX) ? CNT_MAX : elapsed + 1'b1;
    assign cap_en    = (state == MEAS && !start) ? (stop & ~ch_done) : '0;
    assign done_next = ch_done | cap_en;

    // busy is a direct view of the state flop, so it is registered.
    assign busy = (state == MEAS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prescaler <= '0;
            elapsed   <= '0;
            ch_done   <= '0;
            all_done  <= 1'b0;
            lat_last  <= '0;
            lat_max   <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            prescaler <= '0;
            elapsed   <= '0;
            ch_done   <= '0;
            all_done  <= 1'b0;
            lat_last  <= '0;
            lat_max   <= '0;
            overflow  <= 1'b0;
        end else begin
            all_done <= 1'b0;
            if (start) begin
                state     <= MEAS;
                prescaler <= '0;
                elapsed   <= '0;
                ch_done   <= '0;
                lat_last  <= '0;
            end else if (state == MEAS) begin
                if (prescaler == PS_LAST) begin
                    prescaler <= '0;
                    if (elapsed != CNT_MAX) begin
                        elapsed <= elapsed + 1'b1;
                        if (elapsed == CNT_MAX - 1'b1) begin
                            overflow <= 1'b1;
                        end
                    end
                end else begin
                    prescaler <= prescaler + 1'b1;
                end

                for (int i = 0; i < NUM_CH; i++) begin
                    if (cap_en[i]) begin
                        lat_last[i*CNT_W +: CNT_W] <= cap_v;
                        if (cap_v > lat_max[i*CNT_W +: CNT_W]) begin
                            lat_max[i*CNT_W +: CNT_W] <= cap_v;
                        end
                    end
                end
                ch_done <= done_next;

                // Last outstanding channel closes the measurement on this edge.
                if (cap_en != '0 && done_next == '1) begin
                    all_done <= 1'b1;
                    state    <= IDLE;
                end
            end
        end
    end

endmodule
